// File: rtl/random_spawn_scheduler.sv
// random_spawn_scheduler: paces randomized lane spawns in frame units and offers them over a valid/ready handshake
module random_spawn_scheduler #(
  parameter int FRAMES_PER_UNIT = 4,
  parameter int MIN_GAP = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [3:0] random,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [3:0] spawn_lane,
  output logic       spawn_dir,
  output logic [7:0] spawn_count
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, PICK, OFFER, COOLDOWN} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, count_q, count_d;
  logic [3:0] lane_q, lane_d, r;
  logic dir_q, dir_d, valid_q, valid_d;
  assign r = (random == 4'd0) ? 4'd1 : (random > 4'd12) ? 4'd12 : random;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    count_d = count_q;
    lane_d = lane_q;
    dir_d = dir_q;
    if (!enable) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          cnt_d = 8'(r) * 8'(FRAMES_PER_UNIT);
          state_d = WAIT;
        end
        WAIT, COOLDOWN:
          if (startOfFrame) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = (state_q == WAIT) ? PICK : LOAD;
          end
        PICK: begin
          lane_d = r;
          dir_d = r[0];
          state_d = OFFER;
        end
        OFFER:
          if (spawn_ready) begin
            count_d = count_q + 8'd1;
            cnt_d = 8'(MIN_GAP);
            state_d = (MIN_GAP == 0) ? LOAD : COOLDOWN;
          end
        default: state_d = IDLE;
      endcase
    valid_d = (state_d == OFFER);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      count_q <= 8'd0;
      lane_q <= 4'd0;
      dir_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
      lane_q <= lane_d;
      dir_q <= dir_d;
      valid_q <= valid_d;
    end
  assign spawn_valid = valid_q;
  assign spawn_lane = lane_q;
  assign spawn_dir = dir_q;
  assign spawn_count = count_q;
endmodule

// File: tb/tb_random_spawn_scheduler.sv
// tb_random_spawn_scheduler: transaction-level self-checking bench for random_spawn_scheduler
module tb_random_spawn_scheduler;
  localparam int FPU = 4;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic resetN, startOfFrame, enable, spawn_ready;
  logic [3:0] random;
  logic spawn_valid, spawn_dir;
  logic [3:0] spawn_lane;
  logic [7:0] spawn_count;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_count = 8'd0;
  logic [3:0] exp_lane = 4'd0;
  random_spawn_scheduler #(.FRAMES_PER_UNIT(FPU), .MIN_GAP(GAP)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .random(random), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_dir(spawn_dir), .spawn_count(spawn_count)
  );
  always #5 clk = ~clk;
  function automatic int san(input int v);
    return (v == 0) ? 1 : (v > 12) ? 12 : v;
  endfunction
  function automatic logic [3:0] other(input int v);
    return 4'((san(v) % 12) + 1);
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string tag);
    chk(tag, {7'd0, spawn_valid}, 8'd0);
    chk({tag, "_lane"}, {4'd0, spawn_lane}, {4'd0, exp_lane});
    chk({tag, "_count"}, spawn_count, exp_count);
  endtask
  task automatic pulse();
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("gap_valid", {7'd0, spawn_valid}, 8'd0);
    end
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask
  // mode 0: ready held high; mode 1: ready withheld bp cycles; mode 2: enable dropped after bp cycles
  task automatic spawn(input logic [3:0] a, input logic [3:0] b, input int mode, input int bp, input bit noise);
    int n;
    n = san(int'(a)) * FPU;
    spawn_ready = (mode == 0);
    random = a;
    startOfFrame = noise;
    tick();
    startOfFrame = 1'b0;
    random = other(int'(a));
    for (int k = 1; k <= n; k++) begin
      pulse();
      quiet("wait");
    end
    random = b;
    startOfFrame = noise;
    tick();
    startOfFrame = 1'b0;
    random = other(int'(b));
    exp_lane = 4'(san(int'(b)));
    chk("offer_valid", {7'd0, spawn_valid}, 8'd1);
    chk("offer_lane", {4'd0, spawn_lane}, {4'd0, exp_lane});
    chk("offer_dir", {7'd0, spawn_dir}, {7'd0, exp_lane[0]});
    chk("offer_count", spawn_count, exp_count);
    if (mode != 0)
      repeat (bp) begin
        tick();
        chk("hold_valid", {7'd0, spawn_valid}, 8'd1);
        chk("hold_lane", {4'd0, spawn_lane}, {4'd0, exp_lane});
        chk("hold_count", spawn_count, exp_count);
      end
    if (mode == 2) begin
      enable = 1'b0;
      tick();
      quiet("drop");
      tick();
      quiet("drop_idle");
      enable = 1'b1;
      tick();
      quiet("reenable");
      return;
    end
    spawn_ready = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    quiet("accept");
    for (int g = 1; g <= GAP; g++) begin
      pulse();
      quiet("cool");
    end
  endtask
  initial begin
    resetN = 1'b0;
    enable = 1'b1;
    startOfFrame = 1'b0;
    spawn_ready = 1'b0;
    random = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, spawn_valid}, 8'd0);
    chk("rst_lane", {4'd0, spawn_lane}, 8'd0);
    chk("rst_dir", {7'd0, spawn_dir}, 8'd0);
    chk("rst_count", spawn_count, 8'd0);
    resetN = 1'b1;
    tick();
    quiet("post_rst");
    spawn(4'd3, 4'd7, 0, 0, 1'b1);
    spawn(4'd0, 4'd15, 1, 10, 1'b0);
    spawn(4'd2, 4'd4, 2, 3, 1'b1);
    spawn(4'd13, 4'd1, 1, 2, 1'b0);
    for (int i = 0; i < 20; i++)
      spawn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 2),
            $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    while (exp_count != 8'd255) spawn(4'd1, 4'($urandom_range(0, 15)), 0, 0, 1'b0);
    spawn(4'd1, 4'd12, 0, 0, 1'b0);
    chk("wrap_count", spawn_count, 8'd0);
    random = 4'd5;
    tick();
    random = 4'd9;
    pulse();
    pulse();
    #2;
    resetN = 1'b0;
    #1;
    exp_count = 8'd0;
    exp_lane = 4'd0;
    quiet("mid_rst");
    chk("mid_rst_dir", {7'd0, spawn_dir}, 8'd0);
    tick();
    resetN = 1'b1;
    tick();
    quiet("post_mid_rst");
    spawn(4'd2, 4'd6, 1, 1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/random_spawn_scheduler.md
# random_spawn_scheduler

Consumer of the 1–12 keystroke-randomized value. Samples the random value twice per spawn: once to choose a delay in frames, once to choose a lane. It then offers a spawn request to the object/lane drawing logic through a valid/ready handshake. It sits between the random generator and the lane object spawners, pacing obstacle creation in frame units.

## Interface
- FRAMES_PER_UNIT, 4: frames of delay per unit of random value; legal range 1–21.
- MIN_GAP, 2: frames of cooldown after an accepted spawn; legal range 0–255.
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  single-cycle pulse, once per video frame.
- enable  in  1  level; scheduler runs only while high.
- random  in  4  random value; nominally 1–12, any value is tolerated.
- spawn_ready  in  1  consumer can accept a spawn this cycle.
- spawn_valid  out  1  spawn request pending.
- spawn_lane  out  4  lane index 1–12; stable while spawn_valid is high.
- spawn_dir  out  1  direction: 1 = left-to-right, equal to spawn_lane[0].
- spawn_count  out  8  number of accepted spawns; wraps 255→0.

## Operation
- **Sanitize:** r = 1 if random == 0; r = 12 if random > 12; otherwise r = random.
- **Delay counter:** 8-bit, unsigned. The delay load is r*FRAMES_PER_UNIT, maximum 252.

States:
- **IDLE:** outputs idle. Go to LOAD on the cycle enable is high.
- **LOAD:** one cycle. cnt ← r*FRAMES_PER_UNIT, then go to WAIT.
- **WAIT:** cnt decrements on each startOfFrame. A startOfFrame with cnt == 1 goes to PICK.
- **PICK:** one cycle. spawn_lane ← r (a fresh sample), spawn_dir ← r[0], then go to OFFER.
- **OFFER:** spawn_valid = 1.
  - On spawn_valid & spawn_ready: spawn_count increments. If MIN_GAP == 0, go to LOAD. Otherwise cnt ← MIN_GAP and go to COOLDOWN.
- **COOLDOWN:** cnt decrements on each startOfFrame. A startOfFrame with cnt == 1 goes to LOAD.

Rules:
- enable low in any state goes to IDLE on the next edge.
  - spawn_valid drops on that edge; a pending offer is discarded without counting.
  - spawn_lane and spawn_count hold their values.
- spawn_valid is asserted only in OFFER. It never drops without a handshake, except on enable low or reset.
- spawn_lane and spawn_dir change only in PICK.

## Timing
- **Reset:** asynchronous. State = IDLE, spawn_valid = 0, spawn_lane = 0, spawn_dir = 0, spawn_count = 0, cnt = 0.
- **From enable rise:** IDLE to LOAD takes 1 cycle, and LOAD to WAIT takes 1 cycle.
- **Delay:** spawn_valid rises 2 cycles after the r*FRAMES_PER_UNIT-th startOfFrame counted in WAIT (PICK, then OFFER).
  - A startOfFrame arriving during LOAD or PICK is not counted.
- **Handshake:** completes on the edge where valid & ready are both high. spawn_valid is low the next cycle; spawn_count is updated that same edge.
  - spawn_ready high before OFFER has no effect.
  - spawn_ready may be held high; at most one spawn is accepted per OFFER.
- **Cooldown:** MIN_GAP frames counted in COOLDOWN, then LOAD. Next-delay sampling happens in LOAD, not earlier.
- **Reset mid-operation:** forces all reset values immediately; no spawn is counted.

## Test plan
- **Reset, enable held high:** after release, spawn_valid = 0, spawn_count = 0. State is LOAD 1 cycle after resetN rises, then WAIT.
- **Nominal spawn:** FRAMES_PER_UNIT = 4, random = 3 at LOAD, random = 7 at PICK, spawn_ready = 1. spawn_valid rises 2 cycles after the 12th frame pulse, with spawn_lane = 7 and spawn_dir = 1. spawn_valid is high 1 cycle, then spawn_count = 1.
- **Sanitize:** random = 0 at LOAD gives a delay of 4 frames. random = 15 at PICK gives spawn_lane = 12, spawn_dir = 0.
- **Backpressure:** spawn_ready = 0 for 10 cycles in OFFER. spawn_valid and spawn_lane stay stable and spawn_count is unchanged. When ready rises, the accept completes and spawn_count increments once.
- **Enable drop:** enable low during OFFER gives spawn_valid = 0 next cycle, spawn_count unchanged, state IDLE. Re-enabling restarts from LOAD.
- **Cooldown/wrap:** MIN_GAP = 2. The next LOAD occurs on the 2nd frame pulse after accept. Preload spawn_count = 255 via 255 accepts; the next accept gives 0.
